bram_seq_ctrl: RTL and testbench
================================

// Module: bram_seq_ctrl
// PURPOSE
//  Pattern sequencer upstream of the dual-port 16-bit x 1024 block RAM.
//  On start it fills addresses 0..last_addr through port A, then reads them back through port B and compares each word.
//  Reports a pass/fail flag, a saturating error count and the first failing address.
//  Used for power-on memory self-test and as the bring-up stimulus source for the BRAM.
// PARAMETERS
//  DATA_W  16  BRAM word width
//  ADDR_W  10  BRAM address width
//  ERR_W   8   width of err_count; saturates at 2^ERR_W-1
// PORTS
//  clk             in   1       single clock; all logic on rising edge
//  rst_n           in   1       synchronous, active-low reset
//  start           in   1       1-cycle request; sampled only in IDLE
//  last_addr       in   ADDR_W  highest address tested; latched at start
//  seed            in   DATA_W  pattern base; latched at start
//  busy            out  1       high from the cycle after start until done
//  done            out  1       1-cycle pulse when the check completes
//  pass            out  1       err_count==0, valid from done until next start
//  err_count       out  ERR_W   number of miscompares, saturating
//  first_err_addr  out  ADDR_W  address of the first miscompare (0 if none)
//  addr_a          out  ADDR_W  BRAM port A address
//  data_a          out  DATA_W  BRAM port A write data
//  we_a            out  1       BRAM port A write enable
//  addr_b          out  ADDR_W  BRAM port B address
//  data_b          out  DATA_W  tied 0
//  we_b            out  1       tied 0
//  q_b             in   DATA_W  BRAM port B read data; registered, 1-cycle latency
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE; all outputs 0 (including pass), regardless of state.
//   A reset mid-WRITE drops we_a on that same edge. Partially written memory is left as is.
//  FSM: IDLE -> WRITE -> READ -> DRAIN -> DONE -> IDLE.
//   IDLE:  on start=1: latch last_addr and seed, clear err_count/first_err_addr/pass, ptr=0, go to WRITE.
//   WRITE: we_a=1, addr_a=ptr, data_a=pat(ptr); ptr++ each cycle.
//          When ptr==last_addr: ptr=0, go to READ.
//   READ:  addr_b=ptr; ptr++ each cycle; the compare for the address issued in cycle n happens in cycle n+1.
//          When ptr==last_addr: go to DRAIN.
//   DRAIN: 1 cycle; compares the final word.
//   DONE:  done=1 and pass valid for 1 cycle; then IDLE.
//  Latency: with N=last_addr+1, done rises 2N+2 cycles after the start edge.
//   busy is high for 2N+1 cycles.
//  Pattern pat(a) = seed + a, mod 2^DATA_W; a is zero-extended.
//  Compare: a miscompare increments err_count, saturating at all-ones.
//   first_err_addr is captured only on the first miscompare.
//  Address counter: ADDR_W bits. last_addr=2^ADDR_W-1 ends on the equality test and never wraps or repeats.
//   last_addr=0 gives one write, one read, and done at cycle 4.
//  start while busy: ignored, with no effect on the latched config.
//  we_a=0 outside WRITE. addr_a/addr_b hold their last values when idle. data_b=0, we_b=0 always.
// CONFIGURATION
//  BRAM_SEQ_LFSR_EN defined:
//   pat() is the output of a 16-bit Fibonacci LFSR (taps 16,14,13,11).
//   The LFSR loads seed (0 replaced by 16'h0001) on entry to WRITE and steps once per word.
//   It is reloaded on entry to READ, so the expected sequence regenerates identically.
//   Requires DATA_W=16.
//  Not defined: incrementing pattern as above; no LFSR logic is synthesised.
// TESTING  (bench instantiates the BRAM; 10 ns clock)
//  1. rst_n=0 for 2 cycles -> busy=done=we_a=pass=0, err_count=0.
//  2. start, last_addr=31, seed=0 -> mem[i]=i for i=0..31.
//     done at cycle 66; pass=1; err_count=0.
//  3. Bench XORs q_b bit 0 when the read address is 5, last_addr=31, seed=16'h1000
//     -> err_count=1, first_err_addr=5, pass=0.
//  4. last_addr=0, seed=16'hFFFF -> mem[0]=16'hFFFF; done at cycle 4; pass=1.
//     Separately, last_addr=1023, seed=16'hFFFE -> mem[1023]=16'h03FD; no wrap; pass=1.
//  5. Assert start again mid-WRITE -> ignored, same results.
//     Reset at the 10th write cycle -> we_a=0 on that edge; state IDLE; a new start then completes normally.
//  6. BRAM_SEQ_LFSR_EN, seed=0, last_addr=31 -> mem[0]=16'h0001, mem[1]=next LFSR state; pass=1.

Source files
------------

// File: rtl/bram_seq_ctrl.sv
// rtl/bram_seq_ctrl.sv - BRAM fill/readback self-test sequencer
// Optional LFSR pattern source: define BRAM_SEQ_LFSR_EN (requires DATA_W=16).
module bram_seq_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic [DATA_W-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [ADDR_W-1:0] addr_a,
  output logic [DATA_W-1:0] data_a,
  output logic              we_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic [DATA_W-1:0] data_b,
  output logic              we_b,
  input  logic [DATA_W-1:0] q_b
);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] last_q;
  logic [DATA_W-1:0] seed_q;
  logic [DATA_W-1:0] pat;
  logic              rd_v;
  logic [DATA_W-1:0] rd_exp;
  logic [ADDR_W-1:0] rd_addr;
  logic              at_last;

`ifdef BRAM_SEQ_LFSR_EN
  // An all-zero seed would lock the LFSR, so it is forced to 1.
  function automatic logic [DATA_W-1:0] pat_base(input logic [DATA_W-1:0] s);
    return (s == '0) ? DATA_W'(1) : s;
  endfunction

  function automatic logic [DATA_W-1:0] pat_step(input logic [DATA_W-1:0] p);
    return {p[DATA_W-2:0], p[15] ^ p[13] ^ p[12] ^ p[10]};
  endfunction
`else
  function automatic logic [DATA_W-1:0] pat_base(input logic [DATA_W-1:0] s);
    return s;
  endfunction

  function automatic logic [DATA_W-1:0] pat_step(input logic [DATA_W-1:0] p);
    return p + DATA_W'(1);
  endfunction
`endif

  assign at_last = (cnt == last_q);
  assign data_b  = '0;
  assign we_b    = 1'b0;

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start) state_n = S_WRITE;
      S_WRITE: if (at_last) state_n = S_READ;
      S_READ:  if (at_last) state_n = S_DRAIN;
      S_DRAIN: state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      cnt            <= '0;
      last_q         <= '0;
      seed_q         <= '0;
      pat            <= '0;
      rd_v           <= 1'b0;
      rd_exp         <= '0;
      rd_addr        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      addr_a         <= '0;
      data_a         <= '0;
      we_a           <= 1'b0;
      addr_b         <= '0;
    end else begin
      state   <= state_n;
      busy    <= (state == S_WRITE) || (state == S_READ) || (state == S_DRAIN);
      done    <= (state == S_DONE);
      we_a    <= 1'b0;
      // Read stage: q_b for the address issued last cycle arrives this cycle.
      rd_v    <= (state == S_READ);
      rd_exp  <= pat;
      rd_addr <= addr_b;
      case (state)
        S_IDLE: if (start) begin
          last_q         <= last_addr;
          seed_q         <= seed;
          err_count      <= '0;
          first_err_addr <= '0;
          pass           <= 1'b0;
          cnt            <= '0;
          pat            <= pat_base(seed);
          we_a           <= 1'b1;
          addr_a         <= '0;
          data_a         <= pat_base(seed);
        end
        S_WRITE: if (at_last) begin
          cnt    <= '0;
          pat    <= pat_base(seed_q);
          addr_b <= '0;
        end else begin
          cnt    <= cnt + ADDR_W'(1);
          pat    <= pat_step(pat);
          we_a   <= 1'b1;
          addr_a <= cnt + ADDR_W'(1);
          data_a <= pat_step(pat);
        end
        S_READ: if (!at_last) begin
          cnt    <= cnt + ADDR_W'(1);
          pat    <= pat_step(pat);
          addr_b <= cnt + ADDR_W'(1);
        end
        S_DONE: pass <= (err_count == '0);
        default: ;
      endcase
      if (rd_v && (q_b != rd_exp)) begin
        if (err_count != '1) err_count <= err_count + ERR_W'(1);
        if (err_count == '0) first_err_addr <= rd_addr;
      end
    end
  end

endmodule

// File: tb/tb_bram_seq_ctrl.sv
// tb/tb_bram_seq_ctrl.sv - directed scoreboard bench for bram_seq_ctrl with a BRAM model
`timescale 1ns/1ps
module tb_bram_seq_ctrl;
  localparam int DW = 16;
  localparam int AW = 10;
  localparam int EW = 8;

  logic          clk = 1'b0;
  logic          rst_n, start;
  logic [AW-1:0] last_addr;
  logic [DW-1:0] seed;
  logic          busy, done, pass, we_a, we_b;
  logic [EW-1:0] err_count;
  logic [AW-1:0] first_err_addr, addr_a, addr_b;
  logic [DW-1:0] data_a, data_b, q_b;

  logic [DW-1:0] mem [0:1023];
  logic [DW-1:0] q_raw;
  logic [AW-1:0] q_addr;
  bit            flip5;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int lat;
    int nbusy;
    int writes;
    int pass;
    int errs;
    int fea;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  bram_seq_ctrl #(.DATA_W(DW), .ADDR_W(AW), .ERR_W(EW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .last_addr(last_addr), .seed(seed),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_addr(first_err_addr), .addr_a(addr_a), .data_a(data_a), .we_a(we_a),
    .addr_b(addr_b), .data_b(data_b), .we_b(we_b), .q_b(q_b)
  );

  always @(posedge clk) begin
    if (we_a) mem[addr_a] <= data_a;
    q_raw  <= mem[addr_b];
    q_addr <= addr_b;
  end
  assign q_b = q_raw ^ {{(DW-1){1'b0}}, (flip5 && q_addr == 10'd5)};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] m_base(input logic [DW-1:0] s);
`ifdef BRAM_SEQ_LFSR_EN
    return (s == 16'h0000) ? 16'h0001 : s;
`else
    return s;
`endif
  endfunction

  function automatic logic [DW-1:0] m_step(input logic [DW-1:0] p);
`ifdef BRAM_SEQ_LFSR_EN
    return {p[14:0], p[15] ^ p[13] ^ p[12] ^ p[10]};
`else
    return p + 16'd1;
`endif
  endfunction

  task automatic run(input logic [AW-1:0] la, input logic [DW-1:0] sd, input bit flip, input int mid);
    exp_t e, got;
    int n, cyc, nbusy, nwr;
    logic [DW-1:0] p;
    n = int'(la) + 1;
    e.lat = 2*n + 2; e.nbusy = 2*n + 1; e.writes = n;
    e.pass = flip ? 0 : 1; e.errs = flip ? 1 : 0; e.fea = flip ? 5 : 0;
    sb.push_back(e);
    @(negedge clk);
    flip5 = flip; last_addr = la; seed = sd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cyc = 0; nbusy = 0; nwr = we_a ? 1 : 0;
    while (!done && cyc < 2*n + 40) begin
      @(posedge clk); #1;
      cyc++;
      if (busy) nbusy++;
      if (we_a) nwr++;
      if (cyc == mid) begin
        start = 1'b1; last_addr = 10'd3; seed = 16'hABCD;
      end else start = 1'b0;
    end
    start = 1'b0;
    got = sb.pop_front();
    chk("done_seen", done, 1);
    chk("latency", cyc, got.lat);
    chk("busy_cycles", nbusy, got.nbusy);
    chk("write_count", nwr, got.writes);
    chk("pass", pass, got.pass);
    chk("err_count", err_count, got.errs);
    chk("first_err_addr", first_err_addr, got.fea);
    @(posedge clk); #1;
    chk("done_pulse_end", done, 0);
    chk("pass_hold", pass, got.pass);
    chk("we_b", we_b, 0);
    chk("data_b", data_b, 0);
    p = m_base(sd);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("mem[%0d]", i), mem[i], p);
      p = m_step(p);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    rst_n = 1'b0; start = 1'b0; last_addr = '0; seed = '0; flip5 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_we_a", we_a, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err_count", err_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run(10'd31, 16'h0000, 1'b0, -1);
    chk("inc_mem31", mem[31], m_step(m_base(16'h0000)) + 16'd30);
    run(10'd31, 16'h1000, 1'b1, -1);
    run(10'd0, 16'hFFFF, 1'b0, -1);
    run(10'd1023, 16'hFFFE, 1'b0, -1);
`ifndef BRAM_SEQ_LFSR_EN
    chk("mem1023_const", mem[1023], 16'h03FD);
`endif
    run(10'd31, 16'h2000, 1'b0, 10);

    // Reset during the 10th write cycle.
    @(negedge clk);
    last_addr = 10'd31; seed = 16'h7000; start = 1'b1; flip5 = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("we_a_before_reset", we_a, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("reset_we_a", we_a, 0);
    chk("reset_busy", busy, 0);
    chk("reset_addr_a", addr_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_idle_we_a", we_a, 0);
`ifndef BRAM_SEQ_LFSR_EN
    chk("reset_mem9", mem[9], 16'h7009);
    chk("reset_mem10_untouched", mem[10], 16'h200A);
`endif
    run(10'd7, 16'h0055, 1'b0, -1);

`ifdef BRAM_SEQ_LFSR_EN
    run(10'd31, 16'h0000, 1'b0, -1);
    chk("lfsr_mem0", mem[0], 16'h0001);
    chk("lfsr_mem1", mem[1], 16'h0002);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
